// File: rtl/scan_controller.sv
// Four-digit multiplexed display scanner with frame-synchronous double buffering.
// Loads land in a pending buffer and reach the display only at a frame boundary.
module scan_controller #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] value,
  input  logic [3:0]  blank,
  output logic [1:0]  sel,
  output logic [3:0]  digit,
  output logic        dark,
  output logic        tick
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  logic [CW-1:0] cnt;
  logic [15:0]   pend_value;
  logic [3:0]    pend_blank;
  logic          pend;
  logic [15:0]   disp_value;
  logic [3:0]    disp_blank;

  logic          tc;
  logic          frame;
  logic [1:0]    sel_nx;
  logic [15:0]   disp_value_nx;
  logic [3:0]    disp_blank_nx;

  // A load on the boundary cycle bypasses the pending buffer entirely.
  always_comb begin
    tc            = (cnt == LAST);
    frame         = tc && (sel == 2'd3);
    sel_nx        = tc ? sel + 2'd1 : sel;
    disp_value_nx = disp_value;
    disp_blank_nx = disp_blank;
    if (frame && load) begin
      disp_value_nx = value;
      disp_blank_nx = blank;
    end else if (frame && pend) begin
      disp_value_nx = pend_value;
      disp_blank_nx = pend_blank;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      sel        <= 2'd0;
      tick       <= 1'b0;
      digit      <= 4'd0;
      dark       <= 1'b0;
      pend       <= 1'b0;
      pend_value <= 16'd0;
      pend_blank <= 4'd0;
      disp_value <= 16'd0;
      disp_blank <= 4'd0;
    end else begin
      cnt        <= tc ? '0 : cnt + CW'(1);
      sel        <= sel_nx;
      tick       <= tc;
      disp_value <= disp_value_nx;
      disp_blank <= disp_blank_nx;
      // Output nibble tracks the post-edge sel and display, so it moves with sel.
      digit      <= disp_value_nx[{sel_nx, 2'b00} +: 4];
      dark       <= disp_blank_nx[sel_nx];
      if (load) begin
        pend_value <= value;
        pend_blank <= blank;
      end
      if (frame)
        pend <= 1'b0;
      else if (load)
        pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_scan_controller.sv
// Directed bench for scan_controller: one instance at REFRESH_DIV=4, one at REFRESH_DIV=1.
module tb_scan_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load4 = 1'b0, load1 = 1'b0;
  logic [15:0] value4 = '0, value1 = '0;
  logic [3:0]  blank4 = '0, blank1 = '0;
  logic [1:0]  sel4, sel1;
  logic [3:0]  digit4, digit1;
  logic        dark4, dark1, tick4, tick1;

  int checks = 0;
  int errors = 0;
  int k4 = 0;

  always #5 clk = ~clk;

  scan_controller #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .load(load4), .value(value4), .blank(blank4),
    .sel(sel4), .digit(digit4), .dark(dark4), .tick(tick4)
  );

  scan_controller #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load1), .value(value1), .blank(blank1),
    .sel(sel1), .digit(digit1), .dark(dark1), .tick(tick1)
  );

  function automatic logic [3:0] nib(input logic [15:0] v, input logic [1:0] s);
    return v[{s, 2'b00} +: 4];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    k4++;
  endtask

  task automatic release_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    k4 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++; if (sel4 !== 2'd0) begin errors++; $display("FAIL reset_sel4 got %0d want 0", sel4); end
    checks++; if (digit4 !== 4'd0) begin errors++; $display("FAIL reset_digit4 got %0h want 0", digit4); end
    checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL reset_dark4 got %0b want 0", dark4); end
    checks++; if (tick4 !== 1'b0) begin errors++; $display("FAIL reset_tick4 got %0b want 0", tick4); end
    checks++; if (sel1 !== 2'd0) begin errors++; $display("FAIL reset_sel1 got %0d want 0", sel1); end
    checks++; if (digit1 !== 4'd0) begin errors++; $display("FAIL reset_digit1 got %0h want 0", digit1); end
    checks++; if (dark1 !== 1'b0) begin errors++; $display("FAIL reset_dark1 got %0b want 0", dark1); end
    checks++; if (tick1 !== 1'b0) begin errors++; $display("FAIL reset_tick1 got %0b want 0", tick1); end
  endtask

  // Load 1234 at cycle 2; display stays 0 until the boundary at cycle 15.
  task automatic test_first_frame();
    logic [1:0] es;
    logic [3:0] ed;
    release_reset();
    for (int e = 1; e <= 31; e++) begin
      step();
      es = 2'((k4 / 4) % 4);
      ed = (k4 < 16) ? 4'd0 : nib(16'h1234, es);
      checks++; if (sel4 !== es) begin errors++; $display("FAIL first_sel k=%0d got %0d want %0d", k4, sel4, es); end
      checks++; if (tick4 !== (k4 % 4 == 0)) begin errors++; $display("FAIL first_tick k=%0d got %0b want %0b", k4, tick4, (k4 % 4 == 0)); end
      checks++; if (digit4 !== ed) begin errors++; $display("FAIL first_digit k=%0d got %0h want %0h", k4, digit4, ed); end
      checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL first_dark k=%0d got %0b want 0", k4, dark4); end
      if (e == 2) begin load4 = 1'b1; value4 = 16'h1234; blank4 = 4'b0000; end
      if (e == 3) load4 = 1'b0;
    end
  endtask

  task automatic test_free_run();
    int ticks = 0;
    logic [1:0] prev;
    logic [1:0] es;
    prev = sel4;
    for (int i = 0; i < 160; i++) begin
      step();
      if (tick4) ticks++;
      es = 2'((k4 / 4) % 4);
      checks++; if (sel4 !== es) begin errors++; $display("FAIL run_sel k=%0d got %0d want %0d", k4, sel4, es); end
      checks++; if (sel4 !== prev && sel4 !== prev + 2'd1) begin errors++; $display("FAIL run_seq k=%0d got %0d after %0d", k4, sel4, prev); end
      checks++; if (digit4 !== nib(16'h1234, es)) begin errors++; $display("FAIL run_digit k=%0d got %0h want %0h", k4, digit4, nib(16'h1234, es)); end
      prev = sel4;
    end
    checks++; if (ticks !== 40) begin errors++; $display("FAIL run_ticks got %0d want 40", ticks); end
  endtask

  task automatic test_last_wins();
    while (k4 % 16 != 1) step();
    load4 = 1'b1; value4 = 16'hAAAA; blank4 = 4'b0000;
    step();
    value4 = 16'hBBBB;
    step();
    load4 = 1'b0;
    while (k4 % 16 != 0) begin
      checks++; if (digit4 !== nib(16'h1234, sel4)) begin errors++; $display("FAIL lw_old k=%0d got %0h want %0h", k4, digit4, nib(16'h1234, sel4)); end
      step();
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (digit4 !== 4'hB) begin errors++; $display("FAIL lw_new k=%0d got %0h want b", k4, digit4); end
      checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL lw_dark k=%0d got %0b want 0", k4, dark4); end
      step();
    end
  endtask

  task automatic test_boundary_load();
    while (k4 % 16 != 15) step();
    load4 = 1'b1; value4 = 16'hCAFE; blank4 = 4'b1010;
    step();
    load4 = 1'b0;
    checks++; if (sel4 !== 2'd0) begin errors++; $display("FAIL bnd_sel0 got %0d want 0", sel4); end
    checks++; if (digit4 !== 4'hE) begin errors++; $display("FAIL bnd_digit0 got %0h want e", digit4); end
    checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL bnd_dark0 got %0b want 0", dark4); end
    repeat (4) step();
    checks++; if (sel4 !== 2'd1) begin errors++; $display("FAIL bnd_sel1 got %0d want 1", sel4); end
    checks++; if (digit4 !== 4'hF) begin errors++; $display("FAIL bnd_digit1 got %0h want f", digit4); end
    checks++; if (dark4 !== 1'b1) begin errors++; $display("FAIL bnd_dark1 got %0b want 1", dark4); end
    repeat (4) step();
    checks++; if (digit4 !== 4'hA) begin errors++; $display("FAIL bnd_digit2 got %0h want a", digit4); end
    checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL bnd_dark2 got %0b want 0", dark4); end
    repeat (4) step();
    checks++; if (sel4 !== 2'd3) begin errors++; $display("FAIL bnd_sel3 got %0d want 3", sel4); end
    checks++; if (digit4 !== 4'hC) begin errors++; $display("FAIL bnd_digit3 got %0h want c", digit4); end
    checks++; if (dark4 !== 1'b1) begin errors++; $display("FAIL bnd_dark3 got %0b want 1", dark4); end
  endtask

  // Reset in the middle of sel=2 with 5678 pending; it must never surface.
  task automatic test_reset_mid();
    logic [1:0] es;
    while (k4 % 16 != 8) step();
    load4 = 1'b1; value4 = 16'h5678; blank4 = 4'b0000;
    step();
    load4 = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (sel4 !== 2'd0) begin errors++; $display("FAIL rmid_sel got %0d want 0", sel4); end
    checks++; if (digit4 !== 4'd0) begin errors++; $display("FAIL rmid_digit got %0h want 0", digit4); end
    checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL rmid_dark got %0b want 0", dark4); end
    checks++; if (tick4 !== 1'b0) begin errors++; $display("FAIL rmid_tick got %0b want 0", tick4); end
    step();
    step();
    release_reset();
    for (int i = 0; i < 32; i++) begin
      step();
      es = 2'((k4 / 4) % 4);
      checks++; if (sel4 !== es) begin errors++; $display("FAIL rpost_sel k=%0d got %0d want %0d", k4, sel4, es); end
      checks++; if (digit4 !== 4'd0) begin errors++; $display("FAIL rpost_digit k=%0d got %0h want 0", k4, digit4); end
      checks++; if (dark4 !== 1'b0) begin errors++; $display("FAIL rpost_dark k=%0d got %0b want 0", k4, dark4); end
    end
  endtask

  task automatic test_div1();
    logic [1:0] es;
    rst_n = 1'b0;
    step();
    checks++; if (tick1 !== 1'b0) begin errors++; $display("FAIL d1_rst_tick got %0b want 0", tick1); end
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      es = 2'(k4 % 4);
      checks++; if (sel1 !== es) begin errors++; $display("FAIL d1_sel k=%0d got %0d want %0d", k4, sel1, es); end
      checks++; if (tick1 !== 1'b1) begin errors++; $display("FAIL d1_tick k=%0d got %0b want 1", k4, tick1); end
      checks++; if (digit1 !== 4'd0) begin errors++; $display("FAIL d1_pre k=%0d got %0h want 0", k4, digit1); end
    end
    load1 = 1'b1; value1 = 16'h9ABC; blank1 = 4'b0000;
    step();
    load1 = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 8; i++) begin
      es = 2'(k4 % 4);
      checks++; if (sel1 !== es) begin errors++; $display("FAIL d1_lsel k=%0d got %0d want %0d", k4, sel1, es); end
      checks++; if (tick1 !== 1'b1) begin errors++; $display("FAIL d1_ltick k=%0d got %0b want 1", k4, tick1); end
      checks++; if (digit1 !== nib(16'h9ABC, es)) begin errors++; $display("FAIL d1_digit k=%0d got %0h want %0h", k4, digit1, nib(16'h9ABC, es)); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_free_run();
    test_last_wins();
    test_boundary_load();
    test_reset_mid();
    test_div1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
